bridge_uart_tx: RTL and testbench



---
 rtl/bridge_uart_tx.sv | 143 ++++++++++++++
 tb/tb_bridge_uart_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bridge_uart_tx.sv
// Read-response serializer: formats a 16-bit word as "M" + 4 hex digits + line terminator, sent 8N1.
// Define BRIDGE_UART_TX_CRLF_EN for a CR LF terminator (7-byte message); default is LF only (6 bytes).
module bridge_uart_tx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        busy_o,
  output logic        tx
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
`ifdef BRIDGE_UART_TX_CRLF_EN
  localparam int         N_BYTES = 7;
  localparam logic [7:0] TERM_0  = 8'h0D;
`else
  localparam int         N_BYTES = 6;
  localparam logic [7:0] TERM_0  = 8'h0A;
`endif
  localparam logic [2:0]       LAST_BYTE = 3'(N_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_BAUD = CNT_W'(CLOCKS_PER_BAUD - 1);

  typedef enum logic { IDLE, SEND } top_t;
  typedef enum logic [1:0] { U_START, U_DATA, U_STOP } uart_t;

  top_t             top_q, top_d;
  uart_t            ust_q, ust_d;
  logic [2:0]       byte_q, byte_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic             tx_q, tx_d;
  logic [15:0]      data_q;
  logic             load;
  logic             baud_last;
  logic [7:0]       cur_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'd0, nib};
    else             return 8'h37 + {4'd0, nib};
  endfunction

  function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [15:0] d);
    case (idx)
      3'd0:    return 8'h4D;
      3'd1:    return hex_ascii(d[15:12]);
      3'd2:    return hex_ascii(d[11:8]);
      3'd3:    return hex_ascii(d[7:4]);
      3'd4:    return hex_ascii(d[3:0]);
      3'd5:    return TERM_0;
      default: return 8'h0A;
    endcase
  endfunction

  assign baud_last = (baud_q == LAST_BAUD);
  assign cur_byte  = msg_byte(byte_q, data_q);

  always_comb begin
    top_d  = top_q;
    ust_d  = ust_q;
    byte_d = byte_q;
    bit_d  = bit_q;
    baud_d = baud_q;
    tx_d   = tx_q;
    load   = 1'b0;
    case (top_q)
      IDLE: begin
        tx_d = 1'b1;
        if (valid_i && !rw_i) begin
          load   = 1'b1;
          top_d  = SEND;
          ust_d  = U_START;
          byte_d = 3'd0;
          bit_d  = 3'd0;
          baud_d = '0;
          tx_d   = 1'b0;
        end
      end
      SEND: begin
        baud_d = baud_last ? '0 : baud_q + 1'b1;
        // Bit boundaries: tx is loaded with the next bit on the edge that ends the current one.
        if (baud_last) begin
          case (ust_q)
            U_START: begin
              ust_d = U_DATA;
              bit_d = 3'd0;
              tx_d  = cur_byte[0];
            end
            U_DATA: begin
              if (bit_q == 3'd7) begin
                ust_d = U_STOP;
                tx_d  = 1'b1;
              end else begin
                bit_d = bit_q + 3'd1;
                tx_d  = cur_byte[bit_q + 3'd1];
              end
            end
            default: begin
              if (byte_q == LAST_BYTE) begin
                top_d = IDLE;
                ust_d = U_START;
                tx_d  = 1'b1;
              end else begin
                byte_d = byte_q + 3'd1;
                ust_d  = U_START;
                tx_d   = 1'b0;
              end
            end
          endcase
        end
      end
      default: top_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q  <= IDLE;
      ust_q  <= U_START;
      byte_q <= 3'd0;
      bit_q  <= 3'd0;
      baud_q <= '0;
      tx_q   <= 1'b1;
    end else begin
      top_q  <= top_d;
      ust_q  <= ust_d;
      byte_q <= byte_d;
      bit_q  <= bit_d;
      baud_q <= baud_d;
      tx_q   <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) data_q <= rdata_i;
  end

  assign busy_o = (top_q == SEND);
  assign tx     = tx_q;

endmodule

// File: tb/tb_bridge_uart_tx.sv
// Directed bench for bridge_uart_tx: UART decoder on tx, busy length and message content checks.
module tb_bridge_uart_tx;

  localparam int CPB = 10;
`ifdef BRIDGE_UART_TX_CRLF_EN
  localparam int  N_BYTES = 7;
  localparam bit  CRLF    = 1'b1;
`else
  localparam int  N_BYTES = 6;
  localparam bit  CRLF    = 1'b0;
`endif
  localparam int MSG_CYC = N_BYTES * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rdata_i = '0;
  logic        rw_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        busy_o;
  logic        tx;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  bridge_uart_tx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk(clk), .rst(rst), .rdata_i(rdata_i), .rw_i(rw_i),
    .valid_i(valid_i), .busy_o(busy_o), .tx(tx)
  );

  always #5 clk = ~clk;

  // Receiver: detect start at a falling-edge sample, then sample each bit at its centre.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_msg(input string s);
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
    if (CRLF) expq.push_back(8'h0D);
    expq.push_back(8'h0A);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_len"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      check($sformatf("%s_b%0d", tag, i), rxq[i], expq[i]);
    rxq.delete();
    expq.delete();
  endtask

  // Caller is at a falling edge; the request is seen at the next rising edge.
  task automatic pulse(input logic [15:0] d, input logic rw);
    rdata_i = d;
    rw_i    = rw;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    rw_i    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 4 * MSG_CYC) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, busy_o, 0);
  endtask

  initial begin
    int n;
    int bad;
    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    check("idle_100", bad, 0);

    // Read 0x0069: latency, busy length, content
    pulse(16'h0069, 1'b0);
    check("lat_busy", busy_o, 1);
    check("lat_tx", tx, 0);
    n = 1;
    while (busy_o && n < 4 * MSG_CYC) begin
      @(negedge clk);
      if (busy_o) n++;
    end
    check("busy_len", n, MSG_CYC);
    repeat (20) @(negedge clk);
    add_msg("M0069");
    check_rx("rd0069");

    // Write is ignored
    pulse(16'h0042, 1'b1);
    bad = 0;
    repeat (MSG_CYC) begin
      if (tx !== 1'b1 || busy_o !== 1'b0) bad++;
      @(negedge clk);
    end
    check("wr_quiet", bad, 0);
    check_rx("wr0042");

    // Second request while busy is dropped
    pulse(16'hBEEF, 1'b0);
    repeat (199) @(negedge clk);
    pulse(16'h1234, 1'b0);
    wait_idle("beef");
    repeat (MSG_CYC + 50) @(negedge clk);
    check("drop_busy", busy_o, 0);
    add_msg("MBEEF");
    check_rx("beef");

    // Back-to-back on the first idle cycle
    pulse(16'hA5F0, 1'b0);
    wait_idle("a5f0");
    pulse(16'h0001, 1'b0);
    check("b2b_busy", busy_o, 1);
    wait_idle("b2b");
    repeat (20) @(negedge clk);
    add_msg("MA5F0");
    add_msg("M0001");
    check_rx("b2b");

    // Reset during the third byte aborts the message
    pulse(16'hFFFF, 1'b0);
    repeat (2 * 10 * CPB + 35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy_o, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    rxq.delete();
    pulse(16'h0000, 1'b0);
    wait_idle("after_rst");
    repeat (20) @(negedge clk);
    add_msg("M0000");
    check_rx("m0000");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
